mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the single shared instruction/data memory of the multicycle core.
//  - Port 0 (core) is the control unit's fetch/load/store port; port 1 (ext) is the loader/debug port.
//  - Serialises accesses and holds each one for a fixed number of memory cycles.
//  - Returns a one-cycle ack (with read data) that the control unit waits on before leaving memory states.
// PARAMETERS
//  ADDR_W   32  address width, passed through unmodified (no alignment check)
//  DATA_W   32  data width
//  MEM_LAT  2   cycles mem_addr is held before read capture; >=1 (1 = combinational RAM, 2 = registered RAM)
// PORTS
//  cclk        in   1       clock, all state on rising edge
//  rstb        in   1       asynchronous, active-low reset
//  core_req    in   1       core access request; held with addr/we/wdata stable until core_ack
//  core_we     in   1       1 = write, 0 = read
//  core_addr   in   ADDR_W  core address
//  core_wdata  in   DATA_W  core write data
//  core_rdata  out  DATA_W  read data, valid while core_ack=1, held afterwards
//  core_ack    out  1       one-cycle completion pulse
//  ext_req/ext_we/ext_addr/ext_wdata/ext_rdata/ext_ack   same as core_*, for the ext port
//  mem_en      out  1       memory access active
//  mem_we      out  1       memory write strobe
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data
//  busy        out  1       1 whenever state != IDLE
//  owner       out  1       current/last granted port: 0 = core, 1 = ext
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all outputs 0; last_winner=1, so the first tie goes to core.
//  FSM: IDLE -> ACCESS (MEM_LAT cycles, down-counter) -> DONE (1 cycle) -> IDLE.
//  IDLE arbitration (sampled on the clock edge):
//   - if any req is high, pick the winner; register owner, mem_addr, mem_wdata, we_q; go to ACCESS.
//   - tie: round-robin, winner = ~last_winner; last_winner updates on every grant.
//  ACCESS:
//   - mem_en=1 for all MEM_LAT cycles; mem_addr/mem_wdata stay constant.
//   - mem_we=we_q only in the first ACCESS cycle (exactly one write strobe per write).
//   - On the edge closing the last ACCESS cycle, reads capture mem_rdata into owner's rdata register.
//  DONE:
//   - mem_en=mem_we=0; owner's ack=1 for exactly this cycle; the other port's ack stays 0.
//   - No arbitration in DONE; the next grant happens in the following IDLE cycle.
//  Latency: req seen in IDLE cycle N -> ack in cycle N+MEM_LAT+1; minimum access period MEM_LAT+2 cycles.
//  Port rules:
//   - A requester deasserts req the cycle after ack; a req still high in the next IDLE cycle is a new access.
//   - Inputs of the non-granted port are ignored. The granted port's inputs are used only in IDLE (registered).
//   - rdata registers change only on a read capture for that port; writes leave rdata unchanged.
//  Boundary cases:
//   - Req dropped mid-ACCESS: the access completes (a write is committed) and ack still pulses.
//   - Reset mid-ACCESS: mem_en/mem_we drop immediately, no ack, in-flight access abandoned, state=IDLE.
//   - Counter wrap: the counter is reloaded on every grant, never free-running.
//   - MEM_LAT=1: ACCESS is one cycle with mem_we and capture in the same cycle.
// CONFIGURATION
//  MEMARB_FIXED_PRIO_EN defined: ties always go to core; ext is served only when core_req=0 in IDLE.
//   - last_winner still updates but is not used.
//  Undefined (default): round-robin tie-break as above.
//  The macro changes nothing else: timing, ports and reset are identical.
// TESTING (MEM_LAT=2, cycle 0 = first IDLE cycle after reset release)
//  1. core read 0x10 (memory returns 0xDEADBEEF) -> mem_en cyc 1-2, mem_we=0; core_ack=1 cyc 3 with core_rdata=0xDEADBEEF; ext_ack=0.
//  2. ext write 0x40 <- 0x12345678 -> mem_we=1 in cyc 1 only, mem_addr=0x40; ext_ack cyc 3; ext_rdata unchanged.
//  3. core and ext req together at cyc 0, each dropping req after its ack -> core granted first (core_ack cyc 3); ext granted cyc 4, ext_ack cyc 7.
//  4. both reqs held high for 6 accesses -> owner sequence 0,1,0,1,0,1; with MEMARB_FIXED_PRIO_EN -> 0,0,0,0,0,0.
//  5. ext write, rstb low during cyc 2 -> mem_en=mem_we=0 at once, no ack; after release, a tie grants core first.
//  6. core read, core_req dropped at cyc 1 -> access still runs to completion; core_ack still pulses in cyc 3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Two-requester arbiter/sequencer for the single shared instruction/data
//   memory of the multicycle core. Port 0 (core) is the control unit's
//   fetch/load/store port, port 1 (ext) is the loader/debug port. Each granted
//   access drives the memory for MEM_LAT cycles, then returns a one-cycle ack
//   (with read data for reads) in a DONE cycle before the next arbitration.
//
//   FSM: IDLE -> ACCESS (MEM_LAT cycles) -> DONE (1 cycle) -> IDLE
//
// Parameters
//   ADDR_W   address width (passed through, no alignment check)
//   DATA_W   data width
//   MEM_LAT  cycles mem_addr is held before read capture (>= 1)
//
// Ports
//   cclk, rstb                  clock (rising edge), async active-low reset
//   core_req/we/addr/wdata      core request, held stable until core_ack
//   core_rdata, core_ack        core read data (held), one-cycle completion
//   ext_*                       same as core_* for the ext port
//   mem_en/we/addr/wdata        memory request side
//   mem_rdata                   memory read data
//   busy                        state != IDLE
//   owner                       current/last granted port (0 core, 1 ext)
//
// Configuration macro
//   MEMARB_FIXED_PRIO_EN  defined: ties always go to core (fixed priority).
//                         undefined: round-robin tie-break.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int            CW      = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LD  = CW'(MEM_LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_owner;
    logic              r_last_winner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_ext_rdata;

    logic w_winner;
    logic w_access;

    // Winner among the requesters; only meaningful when at least one req is high.
    always_comb begin
        w_winner = ext_req;
        if (core_req && ext_req) begin
`ifdef MEMARB_FIXED_PRIO_EN
            w_winner = 1'b0;
`else
            w_winner = ~r_last_winner;
`endif
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_owner       <= 1'b0;
            r_last_winner <= 1'b1;      // first tie after reset goes to core
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_core_rdata  <= '0;
            r_ext_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (core_req || ext_req) begin
                        r_state       <= S_ACCESS;
                        r_cnt         <= CNT_LD;   // reloaded on every grant
                        r_owner       <= w_winner;
                        r_last_winner <= w_winner;
                        r_we          <= w_winner ? ext_we    : core_we;
                        r_addr        <= w_winner ? ext_addr  : core_addr;
                        r_wdata       <= w_winner ? ext_wdata : core_wdata;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_DONE;
                        // Read capture on the edge closing the last ACCESS cycle.
                        if (!r_we) begin
                            if (r_owner) r_ext_rdata  <= mem_rdata;
                            else         r_core_rdata <= mem_rdata;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_access   = (r_state == S_ACCESS);
    assign mem_en     = w_access;
    // Count equals the reload value only in the first ACCESS cycle: one strobe per write.
    assign mem_we     = w_access && r_we && (r_cnt == CNT_LD);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = (r_state != S_IDLE);
    assign owner      = r_owner;
    assign core_ack   = (r_state == S_DONE) && !r_owner;
    assign ext_ack    = (r_state == S_DONE) &&  r_owner;
    assign core_rdata = r_core_rdata;
    assign ext_rdata  = r_ext_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_ack;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy, owner;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .cclk(cclk), .rstb(rstb),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 cclk = ~cclk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_own;

        // ---- reset state ----
        step(); step();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_owner",  32'(owner),  32'd0);
        chk("rst_acks",   32'({core_ack, ext_ack}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_core_rdata", core_rdata, 32'd0);
        rstb = 1'b1;
        step();

        // ---- 1: core read 0x10 ----
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        chk("t1_c0_mem_en", 32'(mem_en), 32'd0);
        step();
        chk("t1_c1_mem_en", 32'(mem_en), 32'd1);
        chk("t1_c1_mem_we", 32'(mem_we), 32'd0);
        chk("t1_c1_addr", mem_addr, 32'h10);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        chk("t1_c1_owner", 32'(owner), 32'd0);
        step();
        chk("t1_c2_mem_en", 32'(mem_en), 32'd1);
        chk("t1_c2_mem_we", 32'(mem_we), 32'd0);
        chk("t1_c2_ack", 32'(core_ack), 32'd0);
        step();
        chk("t1_c3_core_ack", 32'(core_ack), 32'd1);
        chk("t1_c3_ext_ack", 32'(ext_ack), 32'd0);
        chk("t1_c3_rdata", core_rdata, 32'hDEADBEEF);
        chk("t1_c3_mem_en", 32'(mem_en), 32'd0);
        core_req = 1'b0;
        step();
        chk("t1_c4_ack", 32'(core_ack), 32'd0);
        chk("t1_c4_busy", 32'(busy), 32'd0);
        chk("t1_c4_rdata_held", core_rdata, 32'hDEADBEEF);

        // ---- 2: ext write 0x40 <- 0x12345678 ----
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h12345678;
        mem_rdata = 32'hCAFEF00D;
        step();
        chk("t2_c1_mem_we", 32'(mem_we), 32'd1);
        chk("t2_c1_addr", mem_addr, 32'h40);
        chk("t2_c1_wdata", mem_wdata, 32'h12345678);
        chk("t2_c1_owner", 32'(owner), 32'd1);
        step();
        chk("t2_c2_mem_we", 32'(mem_we), 32'd0);
        chk("t2_c2_mem_en", 32'(mem_en), 32'd1);
        chk("t2_c2_addr", mem_addr, 32'h40);
        step();
        chk("t2_c3_ext_ack", 32'(ext_ack), 32'd1);
        chk("t2_c3_core_ack", 32'(core_ack), 32'd0);
        chk("t2_c3_ext_rdata", ext_rdata, 32'd0);
        ext_req = 1'b0; ext_we = 1'b0;
        step();

        // ---- 3: simultaneous requests, last winner was ext -> core first ----
        core_req = 1'b1; core_addr = 32'h20;
        ext_req  = 1'b1; ext_addr  = 32'h30;
        mem_rdata = 32'h11111111;
        step();
        chk("t3_c1_owner", 32'(owner), 32'd0);
        chk("t3_c1_addr", mem_addr, 32'h20);
        step(); step();
        chk("t3_c3_core_ack", 32'(core_ack), 32'd1);
        chk("t3_c3_ext_ack", 32'(ext_ack), 32'd0);
        chk("t3_c3_core_rdata", core_rdata, 32'h11111111);
        step();
        core_req = 1'b0;
        mem_rdata = 32'h22222222;
        chk("t3_c4_busy", 32'(busy), 32'd0);
        step();
        chk("t3_c5_owner", 32'(owner), 32'd1);
        chk("t3_c5_addr", mem_addr, 32'h30);
        step(); step();
        chk("t3_c7_ext_ack", 32'(ext_ack), 32'd1);
        chk("t3_c7_ext_rdata", ext_rdata, 32'h22222222);
        chk("t3_c7_core_rdata", core_rdata, 32'h11111111);
        ext_req = 1'b0;
        step();

        // ---- 4: both held for 6 accesses ----
        core_req = 1'b1; ext_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef MEMARB_FIXED_PRIO_EN
            exp_own = 1'b0;
`else
            exp_own = i[0];
`endif
            step();
            chk($sformatf("t4_owner_%0d", i), 32'(owner), 32'(exp_own));
            step(); step();
            chk($sformatf("t4_acks_%0d", i), 32'({core_ack, ext_ack}),
                exp_own ? 32'd1 : 32'd2);
            step();
        end
        core_req = 1'b0; ext_req = 1'b0;
        step();

        // ---- 5: reset in the middle of an ext write ----
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h50; ext_wdata = 32'hA5A5A5A5;
        step();
        chk("t5_c1_mem_we", 32'(mem_we), 32'd1);
        step();
        rstb = 1'b0;
        #1;
        chk("t5_rst_mem_en", 32'(mem_en), 32'd0);
        chk("t5_rst_mem_we", 32'(mem_we), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        ext_req = 1'b0; ext_we = 1'b0;
        step();
        chk("t5_c3_acks", 32'({core_ack, ext_ack}), 32'd0);
        rstb = 1'b1;
        step();
        core_req = 1'b1; core_addr = 32'h70;
        ext_req  = 1'b1; ext_addr  = 32'h74;
        mem_rdata = 32'h77777777;
        step();
        chk("t5_tie_owner", 32'(owner), 32'd0);
        chk("t5_tie_addr", mem_addr, 32'h70);
        step(); step();
        chk("t5_core_ack", 32'(core_ack), 32'd1);
        chk("t5_core_rdata", core_rdata, 32'h77777777);
        core_req = 1'b0; ext_req = 1'b0;
        step();

        // ---- 6: core read with req dropped mid-access ----
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h60; mem_rdata = 32'h66666666;
        step();
        core_req = 1'b0;
        chk("t6_c1_mem_en", 32'(mem_en), 32'd1);
        step();
        chk("t6_c2_mem_en", 32'(mem_en), 32'd1);
        step();
        chk("t6_c3_core_ack", 32'(core_ack), 32'd1);
        chk("t6_c3_core_rdata", core_rdata, 32'h66666666);
        step();
        chk("t6_c4_busy", 32'(busy), 32'd0);
        chk("t6_c4_ack", 32'(core_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
